ifetch_queue: RTL

//  Instruction fetch stage upstream of the decode/execute core. Owns the fetch PC.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/instr_fifo.sv | 71 +++++++
 rtl/ifetch_queue.sv | 94 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core widths, opcode field constants and predecode helper
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 30;

    // Branch opcode lives in bits [27:25].
    localparam logic [2:0] OPC_BRANCH     = 3'b101;
    localparam int         OPC_BRANCH_MSB = 27;
    localparam int         OPC_BRANCH_LSB = 25;

    // ADD opcode lives in bits [30:24].
    localparam logic [6:0] OPC_ADD        = 7'b0010001;
    localparam int         OPC_ADD_MSB    = 30;
    localparam int         OPC_ADD_LSB    = 24;

    // Branch offset field.
    localparam int         BR_OFFSET_MSB  = 23;
    localparam int         BR_OFFSET_LSB  = 0;

    function automatic logic is_branch_op(input logic [INSTR_W-1:0] instr);
        return instr[OPC_BRANCH_MSB:OPC_BRANCH_LSB] == OPC_BRANCH;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - DEPTH-entry synchronous FIFO with flush and occupancy count
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   flush             synchronous clear; wins over push and pop
//   push, push_data   write an entry (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   pop_data          current head entry
//   count             number of stored entries, 0..DEPTH
//   empty             count == 0
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 62
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    import cpu_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign push_ok = push && (count != (PW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch PC, code memory issue and prefetch queue
//
// Ports:
//   clk, reset                      clock and asynchronous active-high reset
//   code_en, code_addr              read request to 1-cycle-latency code memory
//   code_rd                         read data, valid the cycle after code_en
//   redirect_valid, redirect_pc     branch redirect: flush and refetch
//   out_valid, out_ready            downstream handshake
//   out_instr, out_pc               head entry (zero when empty)
//   out_is_branch                   predecoded branch flag of the head
module ifetch_queue #(
    parameter int                   INSTR_W  = cpu_pkg::INSTR_W,
    parameter int                   PC_W     = cpu_pkg::PC_W,
    parameter int                   ADDR_W   = 7,
    parameter int                   DEPTH    = 4,
    parameter logic [PC_W-1:0]      RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                code_en,
    output logic [ADDR_W-1:0]   code_addr,
    input  logic [INSTR_W-1:0]  code_rd,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [PC_W-1:0]     out_pc,
    output logic                out_is_branch
);
    import cpu_pkg::*;

    localparam int CW = $clog2(DEPTH);

    logic [PC_W-1:0]         fetch_pc;
    logic [PC_W-1:0]         fetch_pc_q;
    logic                    rd_pending;
    logic [CW:0]             count;
    logic                    empty;
    logic [CW+1:0]           committed;
    logic                    push;
    logic                    pop;
    logic [PC_W+INSTR_W-1:0] head;

    // Slots already owned: stored entries plus the read in flight. Issuing only
    // below DEPTH reserves a slot for every return, so the queue cannot overflow.
    // A same-cycle pop is deliberately not credited.
    assign committed = {1'b0, count} + {{(CW+1){1'b0}}, rd_pending};
    assign code_en   = !reset && !redirect_valid && (committed < (CW+2)'(DEPTH));
    assign code_addr = fetch_pc[ADDR_W-1:0];

    // A return landing in a redirect cycle belongs to the old path.
    assign push = rd_pending && !redirect_valid;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            fetch_pc_q <= '0;
            rd_pending <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc   <= redirect_pc;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= code_en;
            if (code_en) begin
                fetch_pc   <= fetch_pc + PC_W'(1);
                fetch_pc_q <= fetch_pc;
            end
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (PC_W + INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({fetch_pc_q, code_rd}),
        .pop       (pop),
        .pop_data  (head),
        .count     (count),
        .empty     (empty)
    );

    assign out_valid     = !empty;
    assign out_instr     = out_valid ? head[INSTR_W-1:0] : '0;
    assign out_pc        = out_valid ? head[PC_W+INSTR_W-1:INSTR_W] : '0;
    assign out_is_branch = out_valid &&
                           (out_instr[OPC_BRANCH_MSB:OPC_BRANCH_LSB] == OPC_BRANCH);

endmodule
